rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
Parametrised successor to the full-screen stripe filler. It fills an arbitrary axis-aligned rectangle on the VGA adapter framebuffer, using one of four colour-pattern modes. The scan is column-major and plots one pixel per clock. The block sits between the top-level control FSM and the VGA adapter's x/y/colour/plot inputs, and uses a start/done handshake.

Parameters:
SCREEN_W, 160, framebuffer width in pixels
SCREEN_H, 120, framebuffer height in pixels
X_W, 8, width of x coordinates
Y_W, 7, width of y coordinates
C_W, 3, width of colour
STRIPE_SHIFT, 0, log2 of stripe/checker cell size in pixels

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
rst_n  in  1  asynchronous active-low reset
start  in  1  request a fill; level-held by the requester
x0  in  X_W  corner A x
y0  in  Y_W  corner A y
x1  in  X_W  corner B x
y1  in  Y_W  corner B y
mode  in  2  pattern select: 0 solid, 1 vertical stripes, 2 horizontal stripes, 3 checkerboard
colour  in  C_W  base colour
done  out  1  fill complete
vga_x  out  X_W  pixel x to the adapter
vga_y  out  Y_W  pixel y to the adapter
vga_colour  out  C_W  pixel colour
vga_plot  out  1  write strobe

Behaviour:
- Reset is asynchronous, active low, and effective at any time, including mid-fill.
  - State goes to IDLE.
  - done, vga_x, vga_y, vga_colour and vga_plot all go to 0.
- All outputs are registered.
- States are IDLE, FILL and DONE.
- IDLE:
  - On the first clk edge with start=1, latch x0, y0, x1, y1, mode and colour. Later changes to these inputs are ignored until the next IDLE.
  - Normalise the corners: xl=min(x0,x1), xh=max(x0,x1); yl and yh likewise.
  - Clip: xh=min(xh,SCREEN_W-1), yh=min(yh,SCREEN_H-1).
  - If xl>SCREEN_W-1 or yl>SCREEN_H-1, the rectangle is empty: go to DONE and plot nothing.
  - Otherwise go to FILL with the counters at (xl,yl).
- FILL:
  - Every cycle, vga_plot=1, with vga_x/vga_y equal to the current pixel and vga_colour equal to the pattern value.
  - The first pixel (xl,yl) appears on the outputs in the cycle after start is sampled.
  - Scan order: y increments fastest, from yl to yh. When y=yh, y wraps to yl and x increments.
  - After pixel (xh,yh) is presented, the next cycle is DONE.
  - Exactly (xh-xl+1)*(yh-yl+1) plot cycles occur.
- Pattern, computed on absolute screen coordinates, with all colour sums taken mod 2^C_W:
  - mode 0: colour
  - mode 1: colour + (x>>STRIPE_SHIFT)
  - mode 2: colour + (y>>STRIPE_SHIFT)
  - mode 3: colour if bit0 of ((x>>STRIPE_SHIFT)^(y>>STRIPE_SHIFT)) is 0, else ~colour
- DONE:
  - done=1 and vga_plot=0; vga_x, vga_y and vga_colour hold their last values.
  - Stays in DONE while start=1.
  - When start=0 is sampled, go to IDLE and drop done to 0 on the same edge.
- start pulses while in FILL or DONE are ignored; a new fill needs start low, then high again.
- Counter arithmetic uses widths X_W+1 and Y_W+1 internally, so comparisons at xh=2^X_W-1 cannot overflow.
- No combinational path exists from any input to any output.

Test Plan:
- Full screen: reset, then x0=0, y0=0, x1=159, y1=119, mode=1, colour=0, STRIPE_SHIFT=0.
  - Expect 19200 consecutive plot cycles, starting at (0,0) one cycle after start.
  - Pixel n is at x=n/120, y=n%120, colour=x%8.
  - done=1 and vga_plot=0 on cycle 19201.
- Swapped corners: x0=5, y0=4, x1=3, y1=2, mode=0, colour=3'b101.
  - Expect 9 pixels in order (3,2),(3,3),(3,4),(4,2)…(5,4), all colour 5.
  - done on cycle 10; dropping start returns done to 0 on the next edge.
- Clipping and empty:
  - x0=150, y0=110, x1=255, y1=127 gives 10×10=100 pixels ending at (159,119).
  - x0=x1=200 gives done on cycle 1 and no vga_plot pulse.
- Checkerboard: mode=3, STRIPE_SHIFT=1, colour=3'b010, rect (0,0)-(3,3).
  - Colours at (0,0), (0,2), (2,0), (2,2) are 2, 5, 5, 2 respectively; (1,1)=2.
- Reset mid-fill: assert rst_n=0 between clock edges during the full-screen fill.
  - All outputs are 0 immediately, before the next edge.
  - After release with start held high, the fill restarts from (xl,yl).
- Horizontal/wrap: mode=2, colour=7, rect (0,0)-(0,9).
  - Colours are 7,0,1,…,6,7,0; the y-wrap-to-x-increment path is exercised with a 2-column rect (0,0)-(1,1).

Source files
------------

// File: rtl/rect_fill_engine_if.sv
// Request/pixel bundle between a fill requester and rect_fill_engine.
// The requester drives the rectangle description; the engine drives the VGA adapter signals.
interface rect_fill_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic           start;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y1;
  logic [1:0]     mode;
  logic [C_W-1:0] colour;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;

  modport master (
    output start, x0, y0, x1, y1, mode, colour,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, x0, y0, x1, y1, mode, colour,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Column-major rectangle filler for the VGA adapter: one pixel per clock,
// four colour patterns, start/done handshake, all outputs registered.
module rect_fill_engine #(
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int C_W          = 3,
  parameter int STRIPE_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rect_fill_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  // One extra bit so the clip and end-of-column compares never wrap.
  localparam logic [X_W:0] X_LAST = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(SCREEN_H - 1);

  state_t         state_reg, state_next;
  logic [X_W:0]   x_cnt_reg, x_cnt_next;
  logic [Y_W:0]   y_cnt_reg, y_cnt_next;
  logic [X_W:0]   xh_reg, xh_next;
  logic [Y_W:0]   yl_reg, yl_next;
  logic [Y_W:0]   yh_reg, yh_next;
  logic [1:0]     mode_reg, mode_next;
  logic [C_W-1:0] colour_reg, colour_next;
  logic           done_reg, done_next;
  logic           plot_reg, plot_next;
  logic [X_W-1:0] vx_reg, vx_next;
  logic [Y_W-1:0] vy_reg, vy_next;
  logic [C_W-1:0] vc_reg, vc_next;

  logic [X_W:0]   in_xl, in_xh, px;
  logic [Y_W:0]   in_yl, in_yh, py;
  logic [1:0]     pm;
  logic [C_W-1:0] pc;
  logic           load_pixel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      x_cnt_reg  <= '0;
      y_cnt_reg  <= '0;
      xh_reg     <= '0;
      yl_reg     <= '0;
      yh_reg     <= '0;
      mode_reg   <= '0;
      colour_reg <= '0;
      done_reg   <= 1'b0;
      plot_reg   <= 1'b0;
      vx_reg     <= '0;
      vy_reg     <= '0;
      vc_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      x_cnt_reg  <= x_cnt_next;
      y_cnt_reg  <= y_cnt_next;
      xh_reg     <= xh_next;
      yl_reg     <= yl_next;
      yh_reg     <= yh_next;
      mode_reg   <= mode_next;
      colour_reg <= colour_next;
      done_reg   <= done_next;
      plot_reg   <= plot_next;
      vx_reg     <= vx_next;
      vy_reg     <= vy_next;
      vc_reg     <= vc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_cnt_next  = x_cnt_reg;
    y_cnt_next  = y_cnt_reg;
    xh_next     = xh_reg;
    yl_next     = yl_reg;
    yh_next     = yh_reg;
    mode_next   = mode_reg;
    colour_next = colour_reg;
    done_next   = done_reg;
    plot_next   = plot_reg;
    vx_next     = vx_reg;
    vy_next     = vy_reg;
    vc_next     = vc_reg;
    px          = x_cnt_reg;
    py          = y_cnt_reg;
    pm          = mode_reg;
    pc          = colour_reg;
    load_pixel  = 1'b0;

    in_xl = (bus.x0 < bus.x1) ? {1'b0, bus.x0} : {1'b0, bus.x1};
    in_xh = (bus.x0 < bus.x1) ? {1'b0, bus.x1} : {1'b0, bus.x0};
    in_yl = (bus.y0 < bus.y1) ? {1'b0, bus.y0} : {1'b0, bus.y1};
    in_yh = (bus.y0 < bus.y1) ? {1'b0, bus.y1} : {1'b0, bus.y0};
    if (in_xh > X_LAST) in_xh = X_LAST;
    if (in_yh > Y_LAST) in_yh = Y_LAST;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          mode_next   = bus.mode;
          colour_next = bus.colour;
          xh_next     = in_xh;
          yl_next     = in_yl;
          yh_next     = in_yh;
          if (in_xl > X_LAST || in_yl > Y_LAST) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            // First pixel is presented straight from the inputs being latched.
            state_next = FILL;
            x_cnt_next = in_xl;
            y_cnt_next = in_yl;
            px         = in_xl;
            py         = in_yl;
            pm         = bus.mode;
            pc         = bus.colour;
            load_pixel = 1'b1;
          end
        end
      end
      FILL: begin
        if (x_cnt_reg == xh_reg && y_cnt_reg == yh_reg) begin
          state_next = DONE;
          done_next  = 1'b1;
          plot_next  = 1'b0;
        end else begin
          if (y_cnt_reg == yh_reg) begin
            px = x_cnt_reg + (X_W+1)'(1);
            py = yl_reg;
          end else begin
            py = y_cnt_reg + (Y_W+1)'(1);
          end
          x_cnt_next = px;
          y_cnt_next = py;
          load_pixel = 1'b1;
        end
      end
      DONE: begin
        plot_next = 1'b0;
        if (!bus.start) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Pattern is evaluated on the absolute coordinates of the pixel being loaded.
    if (load_pixel) begin
      plot_next = 1'b1;
      vx_next   = px[X_W-1:0];
      vy_next   = py[Y_W-1:0];
      unique case (pm)
        2'd0:    vc_next = pc;
        2'd1:    vc_next = pc + C_W'(px >> STRIPE_SHIFT);
        2'd2:    vc_next = pc + C_W'(py >> STRIPE_SHIFT);
        default: vc_next = (px[STRIPE_SHIFT] ^ py[STRIPE_SHIFT]) ? ~pc : pc;
      endcase
    end
  end

  assign bus.done       = done_reg;
  assign bus.vga_plot   = plot_reg;
  assign bus.vga_x      = vx_reg;
  assign bus.vga_y      = vy_reg;
  assign bus.vga_colour = vc_reg;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: vector table with a pixel scoreboard, plus a
// hand-written asynchronous reset during a full-screen fill.
module tb_rect_fill_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rect_fill_engine_if #(.X_W(8), .Y_W(7), .C_W(3)) bus0 ();
  rect_fill_engine_if #(.X_W(8), .Y_W(7), .C_W(3)) bus1 ();

  rect_fill_engine #(
    .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7), .C_W(3), .STRIPE_SHIFT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  rect_fill_engine #(
    .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7), .C_W(3), .STRIPE_SHIFT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  typedef struct {
    string name;
    int    inst;
    int    x0, y0, x1, y1, mode, colour;
    int    exp_n;
  } vec_t;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   seen_col[160][120];
  int   last_x, last_y;
  vec_t vecs[8];

  function automatic int model_col(int mode, int c, int x, int y, int sh);
    int xs = x >> sh;
    int ys = y >> sh;
    case (mode)
      0:       return c;
      1:       return (c + xs) % 8;
      2:       return (c + ys) % 8;
      default: return (((xs ^ ys) & 1) != 0) ? (7 - c) : c;
    endcase
  endfunction

  task automatic push_expected(input vec_t v);
    int xl = (v.x0 < v.x1) ? v.x0 : v.x1;
    int xh = (v.x0 < v.x1) ? v.x1 : v.x0;
    int yl = (v.y0 < v.y1) ? v.y0 : v.y1;
    int yh = (v.y0 < v.y1) ? v.y1 : v.y0;
    int sh = (v.inst == 0) ? 0 : 1;
    pix_t p;
    if (xh > 159) xh = 159;
    if (yh > 119) yh = 119;
    if (xl > 159 || yl > 119) return;
    for (int x = xl; x <= xh; x++) begin
      for (int y = yl; y <= yh; y++) begin
        p.x = x;
        p.y = y;
        p.c = model_col(v.mode, v.colour, x, y, sh);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus0.x0 = 8'(v.x0); bus0.y0 = 7'(v.y0); bus0.x1 = 8'(v.x1); bus0.y1 = 7'(v.y1);
    bus0.mode = 2'(v.mode); bus0.colour = 3'(v.colour);
    bus1.x0 = 8'(v.x0); bus1.y0 = 7'(v.y0); bus1.x1 = 8'(v.x1); bus1.y1 = 7'(v.y1);
    bus1.mode = 2'(v.mode); bus1.colour = 3'(v.colour);
    if (v.inst == 0) bus0.start = 1'b1;
    else             bus1.start = 1'b1;
  endtask

  task automatic scramble();
    bus0.x0 = 8'($urandom); bus0.y0 = 7'($urandom); bus0.x1 = 8'($urandom); bus0.y1 = 7'($urandom);
    bus0.mode = 2'($urandom); bus0.colour = 3'($urandom);
    bus1.x0 = 8'($urandom); bus1.y0 = 7'($urandom); bus1.x1 = 8'($urandom); bus1.y1 = 7'($urandom);
    bus1.mode = 2'($urandom); bus1.colour = 3'($urandom);
  endtask

  // Samples one instance; every plot pops the scoreboard.
  task automatic sample(input int inst, output bit plot, output bit done);
    int   ax, ay, ac;
    pix_t e;
    if (inst == 0) begin
      plot = bus0.vga_plot; done = bus0.done;
      ax = bus0.vga_x; ay = bus0.vga_y; ac = bus0.vga_colour;
    end else begin
      plot = bus1.vga_plot; done = bus1.done;
      ax = bus1.vga_x; ay = bus1.vga_y; ac = bus1.vga_colour;
    end
    if (plot) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c=%0d), expected no plot", ax, ay, ac);
      end else begin
        e = exp_q.pop_front();
        if (ax != e.x || ay != e.y || ac != e.c) begin
          n_fail++;
          $display("FAIL pixel: got (%0d,%0d,c=%0d), expected (%0d,%0d,c=%0d)",
                   ax, ay, ac, e.x, e.y, e.c);
        end
      end
      if (ax < 160 && ay < 120) seen_col[ax][ay] = ac;
      last_x = ax;
      last_y = ay;
    end
  endtask

  task automatic wait_done(input int inst, input int exp_n, input string name, input bit scr);
    int cyc = 0;
    int plots = 0;
    bit p, d;
    forever begin
      @(negedge clk);
      cyc++;
      sample(inst, p, d);
      if (p) plots++;
      if (scr && cyc == 1) scramble();
      if (d) break;
      if (cyc > exp_n + 8) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got no done after %0d cycles, expected done at %0d", name, cyc, exp_n + 1);
        break;
      end
    end
    check({name, "_done_cycle"}, cyc, exp_n + 1);
    check({name, "_plot_count"}, plots, exp_n);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    bit p, d;
    push_expected(v);
    drive(v);
    wait_done(v.inst, v.exp_n, v.name, 1'b1);
    @(negedge clk);
    sample(v.inst, p, d);
    check({v.name, "_done_hold"}, int'(d), 1);
    check({v.name, "_plot_low"}, int'(p), 0);
    if (v.inst == 0) bus0.start = 1'b0;
    else             bus1.start = 1'b0;
    @(negedge clk);
    sample(v.inst, p, d);
    check({v.name, "_done_drop"}, int'(d), 0);
  endtask

  function automatic int outs0();
    return int'({bus0.done, bus0.vga_plot, bus0.vga_x, bus0.vga_y, bus0.vga_colour});
  endfunction

  function automatic int outs1();
    return int'({bus1.done, bus1.vga_plot, bus1.vga_x, bus1.vga_y, bus1.vga_colour});
  endfunction

  initial begin
    bit p, d;
    vec_t full;
    bus0.start = 1'b0; bus1.start = 1'b0;
    scramble();

    vecs[0] = '{"full",    0,   0,   0, 159, 119, 1, 0, 19200};
    vecs[1] = '{"swapped", 0,   5,   4,   3,   2, 0, 5,     9};
    vecs[2] = '{"clip",    0, 150, 110, 255, 127, 0, 3,   100};
    vecs[3] = '{"empty_x", 0, 200,  10, 200,  20, 0, 6,     0};
    vecs[4] = '{"empty_y", 0,   0, 120,   5, 125, 1, 1,     0};
    vecs[5] = '{"checker", 1,   0,   0,   3,   3, 3, 2,    16};
    vecs[6] = '{"hstripe", 0,   0,   0,   0,   9, 2, 7,    10};
    vecs[7] = '{"wrap",    0,   0,   0,   1,   1, 2, 7,     4};

    repeat (3) @(negedge clk);
    check("reset_outputs_inst0", outs0(), 0);
    check("reset_outputs_inst1", outs1(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].name == "swapped") begin
        check("swapped_last_x", last_x, 5);
        check("swapped_last_y", last_y, 4);
      end
      if (vecs[i].name == "clip") begin
        check("clip_last_x", last_x, 159);
        check("clip_last_y", last_y, 119);
      end
      if (vecs[i].name == "checker") begin
        check("checker_0_0", seen_col[0][0], 2);
        check("checker_0_2", seen_col[0][2], 5);
        check("checker_2_0", seen_col[2][0], 5);
        check("checker_2_2", seen_col[2][2], 2);
        check("checker_1_1", seen_col[1][1], 2);
      end
      if (vecs[i].name == "hstripe") begin
        check("hstripe_y0", seen_col[0][0], 7);
        check("hstripe_y1", seen_col[0][1], 0);
        check("hstripe_y9", seen_col[0][9], 0);
      end
      if (vecs[i].name == "wrap") begin
        check("wrap_col1_y0", seen_col[1][0], 7);
        check("wrap_last_x", last_x, 1);
        check("wrap_last_y", last_y, 1);
      end
    end

    // Asynchronous reset in the middle of a full-screen fill, start held high.
    full = vecs[0];
    push_expected(full);
    drive(full);
    repeat (40) begin
      @(negedge clk);
      sample(0, p, d);
    end
    #2 rst_n = 1'b0;
    #1 check("midfill_reset_outputs", outs0(), 0);
    exp_q.delete();
    push_expected(full);
    @(negedge clk);
    check("midfill_reset_held", outs0(), 0);
    rst_n = 1'b1;
    wait_done(0, 19200, "restart", 1'b0);
    bus0.start = 1'b0;
    @(negedge clk);
    sample(0, p, d);
    check("restart_done_drop", int'(d), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
